// File: rtl/loadstore_pkg.sv
// Shared encodings for the ld/sd control unit: RV64 opcode fields, the halt
// word and the FSM state enumeration.
package loadstore_pkg;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [2:0]  FUNCT3_D  = 3'b011;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_SETUP  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_HOLD   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  // True when a 12-bit signed immediate is non-negative and fits in width bits.
  function automatic logic imm_fits(input logic [11:0] imm12, input int width);
    logic [11:0] upper_s;
    upper_s  = imm12 >> width;
    imm_fits = (upper_s == 12'd0);
  endfunction

endpackage

// File: rtl/dec_loadstore.sv
// Combinational field extraction and classification of one instruction word
// into ld / sd / halt / illegal.
module dec_loadstore
  import loadstore_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int OFFSET_W = 5
) (
  input  logic [31:0]         instr_word,
  output logic [REG_W-1:0]    rs1,
  output logic [REG_W-1:0]    rs2,
  output logic [REG_W-1:0]    rd,
  output logic [OFFSET_W-1:0] imm,
  output logic                is_ld,
  output logic                is_sd,
  output logic                is_halt,
  output logic                is_illegal
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [11:0] imm12_s;
  logic        imm_ok_s;

  // Decode fields; an oversized or negative offset is illegal even for a valid op.
  always_comb begin
    opcode_s   = instr_word[6:0];
    funct3_s   = instr_word[14:12];
    rs1        = REG_W'(instr_word[19:15]);
    rs2        = REG_W'(instr_word[24:20]);
    rd         = REG_W'(instr_word[11:7]);
    is_halt    = (instr_word == HALT_WORD);
    is_ld      = (opcode_s == OP_LOAD)  && (funct3_s == FUNCT3_D);
    is_sd      = (opcode_s == OP_STORE) && (funct3_s == FUNCT3_D);
    if (is_sd) begin
      imm12_s = {instr_word[31:25], instr_word[11:7]};
    end else begin
      imm12_s = instr_word[31:20];
    end
    imm_ok_s   = imm_fits(imm12_s, OFFSET_W);
    imm        = imm12_s[OFFSET_W-1:0];
    is_illegal = !is_halt && (!(is_ld || is_sd) || !imm_ok_s);
  end

endmodule

// File: rtl/uc_loadstore.sv
// Multi-cycle fetch/decode/strobe sequencer driving the FD_loadstore datapath
// with stable register addresses and single-cycle write strobes.
module uc_loadstore
  import loadstore_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int OFFSET_W = 5,
  parameter int PC_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                instr_req,
  output logic [PC_W-1:0]     pc,
  input  logic                instr_valid,
  input  logic [31:0]         instr,
  output logic [REG_W-1:0]    Ra,
  output logic [REG_W-1:0]    Rb,
  output logic [REG_W-1:0]    Rw,
  output logic [OFFSET_W-1:0] OFFSET,
  output logic                WE_reg,
  output logic                WE_mem,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  state_t                state_r;
  logic [31:0]           instr_r;
  logic [REG_W-1:0]      rs1_s;
  logic [REG_W-1:0]      rs2_s;
  logic [REG_W-1:0]      rd_s;
  logic [OFFSET_W-1:0]   imm_s;
  logic                  is_ld_s;
  logic                  is_sd_s;
  logic                  is_halt_s;
  logic                  is_illegal_s;

  dec_loadstore #(
    .REG_W    (REG_W),
    .OFFSET_W (OFFSET_W)
  ) u_dec (
    .instr_word (instr_r),
    .rs1        (rs1_s),
    .rs2        (rs2_s),
    .rd         (rd_s),
    .imm        (imm_s),
    .is_ld      (is_ld_s),
    .is_sd      (is_sd_s),
    .is_halt    (is_halt_s),
    .is_illegal (is_illegal_s)
  );

  // Sequencer: every output is set on entry to the state that owns it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      instr_r   <= 32'h0000_0000;
      pc        <= '0;
      Ra        <= '0;
      Rb        <= '0;
      Rw        <= '0;
      OFFSET    <= '0;
      WE_reg    <= 1'b0;
      WE_mem    <= 1'b0;
      instr_req <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r   <= ST_FETCH;
            pc        <= '0;
            instr_req <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end else begin
            state_r   <= state_r;
          end
        end
        ST_FETCH: begin
          if (instr_valid) begin
            instr_r   <= instr;
            instr_req <= 1'b0;
            state_r   <= ST_DECODE;
          end else begin
            instr_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (is_halt_s) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else if (is_illegal_s) begin
            state_r <= ST_ERROR;
            illegal <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state_r <= ST_SETUP;
            Rb      <= rs1_s;
            Rw      <= is_ld_s ? rd_s  : '0;
            Ra      <= is_sd_s ? rs2_s : '0;
            OFFSET  <= imm_s;
          end
        end
        ST_SETUP: begin
          state_r <= ST_WRITE;
          WE_reg  <= is_ld_s;
          WE_mem  <= is_sd_s;
        end
        ST_WRITE: begin
          state_r <= ST_HOLD;
          WE_reg  <= 1'b0;
          WE_mem  <= 1'b0;
        end
        ST_HOLD: begin
          state_r   <= ST_FETCH;
          pc        <= pc + PC_W'(4);
          Ra        <= '0;
          Rb        <= '0;
          Rw        <= '0;
          OFFSET    <= '0;
          instr_req <= 1'b1;
        end
        ST_ERROR: begin
          state_r <= ST_ERROR;
          WE_reg  <= 1'b0;
          WE_mem  <= 1'b0;
        end
        default: begin
          state_r   <= ST_ERROR;
          illegal   <= 1'b1;
          busy      <= 1'b0;
          instr_req <= 1'b0;
          WE_reg    <= 1'b0;
          WE_mem    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uc_loadstore.sv
// Directed bench for uc_loadstore with a tiny register/memory datapath model.
module tb_uc_loadstore;

  localparam int REG_W = 5, OFFSET_W = 5, PC_W = 8;
  localparam logic [31:0] LD15 = 32'h00F0_3283;
  localparam logic [31:0] SD20 = 32'h0050_3A23;
  localparam logic [31:0] LD40 = 32'h0280_3283;
  localparam logic [31:0] ADD  = 32'h0031_00B3;

  logic                clk, reset, start, instr_req, instr_valid;
  logic [PC_W-1:0]     pc;
  logic [31:0]         instr;
  logic [REG_W-1:0]    Ra, Rb, Rw;
  logic [OFFSET_W-1:0] OFFSET;
  logic                WE_reg, WE_mem, busy, done, illegal;

  logic [31:0] imem [0:7];
  logic        ready_en;
  logic [63:0] regs [0:31];
  logic [63:0] dmem [0:63];
  int          we_reg_cnt, we_mem_cnt, fetch_cnt;
  logic [REG_W-1:0]    last_ra, last_rw;
  logic [OFFSET_W-1:0] last_off;
  int checks, errors;

  uc_loadstore #(.REG_W(REG_W), .OFFSET_W(OFFSET_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_req(instr_req), .pc(pc),
    .instr_valid(instr_valid), .instr(instr), .Ra(Ra), .Rb(Rb), .Rw(Rw),
    .OFFSET(OFFSET), .WE_reg(WE_reg), .WE_mem(WE_mem), .busy(busy),
    .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr       = imem[pc[4:2]];
  assign instr_valid = instr_req & ready_en;

  // Datapath model: executes the strobes and counts them.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
      for (int i = 0; i < 64; i++) dmem[i] <= 64'd0;
      dmem[15]   <= 64'd100;
      we_reg_cnt <= 0;
      we_mem_cnt <= 0;
      fetch_cnt  <= 0;
    end else begin
      if (instr_req && instr_valid) fetch_cnt <= fetch_cnt + 1;
      if (WE_reg) begin
        we_reg_cnt <= we_reg_cnt + 1;
        if (Rw != 0) regs[Rw] <= dmem[(int'(regs[Rb]) + int'(OFFSET)) & 63];
        last_rw  <= Rw;
        last_off <= OFFSET;
      end
      if (WE_mem) begin
        we_mem_cnt <= we_mem_cnt + 1;
        dmem[(int'(regs[Rb]) + int'(OFFSET)) & 63] <= regs[Ra];
        last_ra  <= Ra;
        last_off <= OFFSET;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; ready_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int max_cycles);
    int n = 0;
    while (!(done || illegal) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(done || illegal)) begin
      errors++;
      $display("FAIL wait_end: done/illegal not reached after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ready_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_req, pc, Ra, Rb, Rw, OFFSET, WE_reg, WE_mem, busy, done, illegal} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pc=%0d Ra=%0d Rb=%0d Rw=%0d busy=%b done=%b illegal=%b, required all 0",
               pc, Ra, Rb, Rw, busy, done, illegal);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_ld();
    do_reset();
    imem[0] = LD15; imem[1] = 32'h0;
    pulse_start();
    checks++;
    if (instr_req !== 1'b1 || pc !== 8'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL ld_fetch: instr_req=%b pc=%0d busy=%b, required 1/0/1", instr_req, pc, busy);
    end
    repeat (2) @(negedge clk); // DECODE, SETUP
    checks++;
    if (WE_reg !== 1'b0 || Rw !== 5'd5 || Rb !== 5'd0 || OFFSET !== 5'd15) begin
      errors++; $display("FAIL ld_setup: WE_reg=%b Rw=%0d Rb=%0d OFFSET=%0d, required 0/5/0/15", WE_reg, Rw, Rb, OFFSET);
    end
    @(negedge clk); // WRITE
    checks++;
    if (WE_reg !== 1'b1 || WE_mem !== 1'b0 || Rw !== 5'd5 || Rb !== 5'd0 || Ra !== 5'd0 || OFFSET !== 5'd15) begin
      errors++; $display("FAIL ld_write: WE_reg=%b WE_mem=%b Rw=%0d Rb=%0d Ra=%0d OFFSET=%0d, required 1/0/5/0/0/15",
                         WE_reg, WE_mem, Rw, Rb, Ra, OFFSET);
    end
    @(negedge clk); // HOLD
    checks++;
    if (WE_reg !== 1'b0 || Rw !== 5'd5 || OFFSET !== 5'd15) begin
      errors++; $display("FAIL ld_hold: WE_reg=%b Rw=%0d OFFSET=%0d, required 0/5/15", WE_reg, Rw, OFFSET);
    end
    @(negedge clk); // FETCH of next word
    checks++;
    if (pc !== 8'd4 || instr_req !== 1'b1) begin
      errors++; $display("FAIL ld_next_pc: pc=%0d instr_req=%b, required 4/1", pc, instr_req);
    end
    wait_end(20);
    checks++;
    if (done !== 1'b1 || we_reg_cnt !== 1 || regs[5] !== 64'd100) begin
      errors++; $display("FAIL ld_done: done=%b we_reg_cnt=%0d x5=%0d, required 1/1/100", done, we_reg_cnt, regs[5]);
    end
  endtask

  task automatic test_program();
    do_reset();
    imem[0] = LD15; imem[1] = SD20; imem[2] = 32'h0;
    pulse_start();
    wait_end(40);
    checks++;
    if (dmem[20] !== 64'd100 || we_mem_cnt !== 1 || last_ra !== 5'd5 || last_off !== 5'd20) begin
      errors++; $display("FAIL prog_store: MEM20=%0d we_mem_cnt=%0d Ra=%0d OFFSET=%0d, required 100/1/5/20",
                         dmem[20], we_mem_cnt, last_ra, last_off);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || fetch_cnt !== 3 || we_reg_cnt !== 1) begin
      errors++; $display("FAIL prog_done: done=%b busy=%b fetches=%0d we_reg_cnt=%0d, required 1/0/3/1",
                         done, busy, fetch_cnt, we_reg_cnt);
    end
  endtask

  task automatic test_fetch_wait();
    do_reset();
    imem[0] = LD15; imem[1] = 32'h0;
    ready_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_req !== 1'b1 || pc !== 8'd0 || WE_reg !== 1'b0 || WE_mem !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL fetch_wait[%0d]: instr_req=%b pc=%0d WE_reg=%b WE_mem=%b busy=%b, required 1/0/0/0/1",
                           i, instr_req, pc, WE_reg, WE_mem, busy);
      end
      @(negedge clk);
    end
    ready_en = 1'b1;
    wait_end(30);
    checks++;
    if (done !== 1'b1 || we_reg_cnt !== 1 || fetch_cnt !== 2) begin
      errors++; $display("FAIL fetch_wait_end: done=%b we_reg_cnt=%0d fetches=%0d, required 1/1/2", done, we_reg_cnt, fetch_cnt);
    end
  endtask

  task automatic test_illegal(input logic [31:0] word, input string tag);
    do_reset();
    imem[0] = word; imem[1] = 32'h0;
    pulse_start();
    wait_end(20);
    checks++;
    if (illegal !== 1'b1 || done !== 1'b0 || pc !== 8'd0 || busy !== 1'b0 || we_reg_cnt !== 0 || we_mem_cnt !== 0) begin
      errors++; $display("FAIL %s_trap: illegal=%b done=%b pc=%0d busy=%b strobes=%0d/%0d, required 1/0/0/0/0/0",
                         tag, illegal, done, pc, busy, we_reg_cnt, we_mem_cnt);
    end
    pulse_start();
    repeat (3) @(negedge clk);
    checks++;
    if (illegal !== 1'b1 || instr_req !== 1'b0 || busy !== 1'b0 || fetch_cnt !== 1) begin
      errors++; $display("FAIL %s_sticky: illegal=%b instr_req=%b busy=%b fetches=%0d, required 1/0/0/1",
                         tag, illegal, instr_req, busy, fetch_cnt);
    end
    do_reset();
    checks++;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL %s_clear: illegal=%b, required 0", tag, illegal);
    end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    do_reset();
    imem[0] = SD20; imem[1] = 32'h0;
    pulse_start();
    while (WE_mem !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (WE_mem !== 1'b1) begin
      errors++; $display("FAIL mid_write_reach: WE_mem=%b, required 1", WE_mem);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({instr_req, pc, Ra, Rb, Rw, OFFSET, WE_reg, WE_mem, busy, done, illegal} !== '0) begin
      errors++; $display("FAIL mid_write_kill: WE_mem=%b Ra=%0d OFFSET=%0d busy=%b, required all 0",
                         WE_mem, Ra, OFFSET, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    imem[0] = LD15; imem[1] = 32'h0;
    pulse_start();
    wait_end(20);
    pulse_start();
    checks++;
    if (done !== 1'b0 || pc !== 8'd0 || instr_req !== 1'b1) begin
      errors++; $display("FAIL restart_fetch: done=%b pc=%0d instr_req=%b, required 0/0/1", done, pc, instr_req);
    end
    wait_end(20);
    checks++;
    if (done !== 1'b1 || we_reg_cnt !== 2 || fetch_cnt !== 4 || last_rw !== 5'd5 || last_off !== 5'd15) begin
      errors++; $display("FAIL restart_repeat: done=%b we_reg_cnt=%0d fetches=%0d Rw=%0d OFFSET=%0d, required 1/2/4/5/15",
                         done, we_reg_cnt, fetch_cnt, last_rw, last_off);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; ready_en = 1'b1;
    for (int i = 0; i < 8; i++) imem[i] = 32'h0;
    test_reset();
    test_single_ld();
    test_program();
    test_fetch_wait();
    test_illegal(LD40, "ld40");
    test_illegal(ADD, "add");
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
